seven_seg_mux: RTL and testbench
================================

Name: seven_seg_mux

Overview:
Time-multiplexed driver for a bank of NUM_DIGITS common-anode seven-segment displays sharing one segment bus. It holds a captured hex value and scans digits round-robin at a fixed refresh rate. Per-digit features: blanking, blinking, decimal point and leading-zero suppression. It sits between game logic (score/level/round counters) and the board display pins, and replaces per-digit combinational decoders.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=1)
REFRESH_DIV, 50000, clk cycles each digit stays active (>=2)
BLINK_DIV, 25000000, clk cycles per blink half-period (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
value_in  in  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i; digit 0 = least significant
load  in  1  capture value_in, dp_in, blank_mask, blink_mask into shadow registers
dp_in  in  NUM_DIGITS  decimal point request per digit (1 = lit)
blank_mask  in  NUM_DIGITS  1 = digit forced dark
blink_mask  in  NUM_DIGITS  1 = digit dark during blink off-phase
lz_suppress  in  1  1 = suppress leading zeros (live, not shadowed)
seg_out  out  7  segments {g,f,e,d,c,b,a}, active-low
dp_out  out  1  decimal point, active-low
an_out  out  NUM_DIGITS  anode enables, active-low, one-hot-low
digit_idx  out  clog2(NUM_DIGITS) (min 1)  index of digit currently driven

Behaviour:
- Reset: seg_out=7'h7F, dp_out=1, an_out=all ones, digit_idx=0, refresh and blink counters=0, blink phase=0 (on), all shadow registers=0.
- Shadow capture: when load=1, the shadow registers take their inputs on the next edge. The display uses shadow values only, so the value cannot tear mid-scan. load held high gives continuous update.
- Refresh counter: counts 0..REFRESH_DIV-1 and wraps. On the wrap cycle, scan index advances (NUM_DIGITS-1 wraps to 0).
- Blink counter: counts 0..BLINK_DIV-1. On wrap, blink phase toggles (0 = on, 1 = off).
- Output stage is fully registered. Outputs reflect scan index and shadow state with 1-cycle latency. an_out, seg_out, dp_out and digit_idx always change on the same edge.
- Digit dark condition for scan index k, evaluated against shadow state. Digit k is dark if any of:
  - blank_mask[k]=1
  - blink_mask[k]=1 and blink phase=1
  - lz_suppress=1, k!=0, and nibbles k..NUM_DIGITS-1 are all zero
- Digit 0 is never leading-zero suppressed.
- Dark digit: seg_out=7'h7F, dp_out=1; an_out[k] is still driven low, which keeps brightness uniform.
- Lit digit encoding, hex 0..F, active-low {g..a}: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- dp_out=~dp_in_shadow[k] when the digit is lit.
- an_out: exactly one bit low at all times after the first post-reset edge. That bit is bit k = digit_idx.
- NUM_DIGITS=1: index stays 0; an_out=1'b0 permanently after reset.
- Simultaneous load and scan advance: the new digit uses the newly loaded shadow values from the following cycle. No glitch is permitted on the cycle of capture beyond the normal 1-cycle latency.
- Reset mid-scan: returns to digit 0 with all outputs dark on the next edge. Shadow is cleared.

Test Plan:
- Reset then release, NUM_DIGITS=4, REFRESH_DIV=4, load value 16'h12AF -> digit_idx sequence 0,1,2,3,0 every 4 cycles. Required per-digit outputs:
  - digit 0: an_out=4'b1110, seg_out=7'h0E (F)
  - digit 1: an_out=4'b1101, seg_out=7'h08 (A)
  - digit 2: seg_out=7'h24
  - digit 3: seg_out=7'h79
- Load 16'h0007, lz_suppress=1 -> digits 3,2,1 show seg_out=7'h7F with an_out still cycling; digit 0 shows 7'h78. With lz_suppress=0 -> digits 3..1 show 7'h40.
- Load 16'h0000, lz_suppress=1 -> digit 0 shows 7'h40; digits 1..3 are dark.
- blink_mask=4'b0010, BLINK_DIV=8 -> digit 1 alternates 8 cycles lit / 8 cycles 7'h7F; other digits are unaffected. blank_mask=4'b0100 -> digit 2 is always 7'h7F.
- dp_in=4'b0001 with digit 0 lit -> dp_out=0 only while an_out=4'b1110. Same dp_in with blank_mask[0]=1 -> dp_out=1.
- Assert rst while digit_idx=2 -> next edge: an_out=4'hF, seg_out=7'h7F, digit_idx=0. Change value_in without load -> display is unchanged.

Source files
------------

// File: rtl/seven_seg_mux_if.sv
// Display bus between game logic (master) and the seven-segment scan driver (slave).
// Inputs are captured by the driver on load; outputs are registered board-pin levels.
interface seven_seg_mux_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] value_in;
  logic                    load;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    lz_suppress;
  logic [6:0]              seg_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   an_out;
  logic [IDX_W-1:0]        digit_idx;

  modport master (
    output value_in, load, dp_in, blank_mask, blink_mask, lz_suppress,
    input  seg_out, dp_out, an_out, digit_idx
  );

  modport slave (
    input  value_in, load, dp_in, blank_mask, blink_mask, lz_suppress,
    output seg_out, dp_out, an_out, digit_idx
  );
endinterface

// File: rtl/seven_seg_mux.sv
// Round-robin scan driver for common-anode 7-seg digits; outputs lag scan/shadow state by 1 cycle.
// No backpressure: load is accepted every cycle and the display never stalls.
module seven_seg_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 25000000
) (
  input logic           clk,
  input logic           rst,
  seven_seg_mux_if.slave bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = $clog2(BLINK_DIV);

  logic [NUM_DIGITS-1:0][3:0] val_sh;
  logic [NUM_DIGITS-1:0]      dp_sh;
  logic [NUM_DIGITS-1:0]      blank_sh;
  logic [NUM_DIGITS-1:0]      blink_sh;

  logic [REF_W-1:0] ref_cnt;
  logic [BLK_W-1:0] blk_cnt;
  logic             blink_off;
  logic [IDX_W-1:0] scan_idx;

  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic [IDX_W-1:0]      idx_q;

  logic [NUM_DIGITS-1:0] hi_zero;
  logic                  upper_zero;
  logic                  dark;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0: hex2seg = 7'h40;
      4'h1: hex2seg = 7'h79;
      4'h2: hex2seg = 7'h24;
      4'h3: hex2seg = 7'h30;
      4'h4: hex2seg = 7'h19;
      4'h5: hex2seg = 7'h12;
      4'h6: hex2seg = 7'h02;
      4'h7: hex2seg = 7'h78;
      4'h8: hex2seg = 7'h00;
      4'h9: hex2seg = 7'h10;
      4'hA: hex2seg = 7'h08;
      4'hB: hex2seg = 7'h03;
      4'hC: hex2seg = 7'h46;
      4'hD: hex2seg = 7'h21;
      4'hE: hex2seg = 7'h06;
      default: hex2seg = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      val_sh    <= '0;
      dp_sh     <= '0;
      blank_sh  <= '0;
      blink_sh  <= '0;
      ref_cnt   <= '0;
      blk_cnt   <= '0;
      blink_off <= 1'b0;
      scan_idx  <= '0;
    end else begin
      if (bus.load) begin
        val_sh   <= bus.value_in;
        dp_sh    <= bus.dp_in;
        blank_sh <= bus.blank_mask;
        blink_sh <= bus.blink_mask;
      end
      if (ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
        ref_cnt  <= '0;
        scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end
      if (blk_cnt == BLK_W'(BLINK_DIV - 1)) begin
        blk_cnt   <= '0;
        blink_off <= ~blink_off;
      end else begin
        blk_cnt <= blk_cnt + 1'b1;
      end
    end
  end

  // hi_zero[k]: every nibble from k up to the top digit is zero.
  always_comb begin
    upper_zero = 1'b1;
    hi_zero    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (val_sh[i] == 4'h0);
      hi_zero[i] = upper_zero;
    end
  end

  always_comb begin
    dark = blank_sh[scan_idx]
         | (blink_sh[scan_idx] & blink_off)
         | (bus.lz_suppress & (scan_idx != '0) & hi_zero[scan_idx]);
    seg_nxt = dark ? 7'h7F : hex2seg(val_sh[scan_idx]);
    dp_nxt  = dark | ~dp_sh[scan_idx];
    // Anode stays enabled on dark digits so every digit gets the same duty cycle.
    an_nxt  = ~(NUM_DIGITS'(1) << scan_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
      an_q  <= '1;
      idx_q <= '0;
    end else begin
      seg_q <= seg_nxt;
      dp_q  <= dp_nxt;
      an_q  <= an_nxt;
      idx_q <= scan_idx;
    end
  end

  assign bus.seg_out   = seg_q;
  assign bus.dp_out    = dp_q;
  assign bus.an_out    = an_q;
  assign bus.digit_idx = idx_q;
endmodule

// File: tb/tb_seven_seg_mux.sv
// Bench for seven_seg_mux (4 digits, refresh 4, blink 8): stimulus pushes the expected
// pin state for each edge into a queue; a monitor pops and compares after every edge.
module tb_seven_seg_mux;
  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic [1:0] idx;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  obs_t exp_q[$];

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference state: edges since reset release and the shadow contents the bench loaded.
  int          c_edges = 0;
  logic [15:0] m_val   = '0;
  logic [3:0]  m_dp    = '0;
  logic [3:0]  m_blank = '0;
  logic [3:0]  m_blink = '0;

  seven_seg_mux_if #(.NUM_DIGITS(4)) bus ();

  seven_seg_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLINK_DIV(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    obs_t e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{seg: bus.seg_out, dp: bus.dp_out, an: bus.an_out, idx: bus.digit_idx};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL pins t=%0t: got seg=%h dp=%b an=%b idx=%0d, want seg=%h dp=%b an=%b idx=%0d",
                 $time, a.seg, a.dp, a.an, a.idx, e.seg, e.dp, e.an, e.idx);
      end
    end
  end

  // Push the pin state expected after the coming edge, advance the reference, cross the edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      obs_t e;
      int   d;
      logic ph, dk;
      if (rst) begin
        e = '{seg: 7'h7F, dp: 1'b1, an: 4'hF, idx: 2'd0};
      end else begin
        d  = (c_edges / 4) % 4;
        ph = ((c_edges / 8) % 2) == 1;
        dk = m_blank[d] | (m_blink[d] & ph) | (bus.lz_suppress && d != 0 && (m_val >> (4 * d)) == 16'h0);
        e.seg = dk ? 7'h7F : seg_tab[m_val[4*d +: 4]];
        e.dp  = dk ? 1'b1 : ~m_dp[d];
        e.an  = ~(4'b0001 << d);
        e.idx = 2'(d);
      end
      exp_q.push_back(e);
      if (rst) begin
        c_edges = 0;
        m_val = '0; m_dp = '0; m_blank = '0; m_blink = '0;
      end else begin
        c_edges++;
        if (bus.load) begin
          m_val = bus.value_in; m_dp = bus.dp_in;
          m_blank = bus.blank_mask; m_blink = bus.blink_mask;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic load_vals(input logic [15:0] v, input logic [3:0] dp,
                           input logic [3:0] blank, input logic [3:0] blink);
    bus.value_in = v; bus.dp_in = dp; bus.blank_mask = blank; bus.blink_mask = blink;
    bus.load = 1'b1;
    tick(1);
    bus.load = 1'b0;
  endtask

  initial begin
    bus.value_in = '0; bus.load = 1'b0; bus.dp_in = '0;
    bus.blank_mask = '0; bus.blink_mask = '0; bus.lz_suppress = 1'b0;
    @(negedge clk);
    tick(3);
    rst = 1'b0;

    load_vals(16'h12AF, 4'h0, 4'h0, 4'h0);
    tick(20);

    bus.lz_suppress = 1'b1;
    load_vals(16'h0007, 4'h0, 4'h0, 4'h0);
    tick(16);
    bus.lz_suppress = 1'b0;
    tick(16);

    bus.lz_suppress = 1'b1;
    load_vals(16'h0000, 4'h0, 4'h0, 4'h0);
    tick(16);
    bus.lz_suppress = 1'b0;

    load_vals(16'h4321, 4'h0, 4'h0, 4'b0010);
    tick(32);
    load_vals(16'h4321, 4'h0, 4'h0, 4'b1111);
    tick(32);
    load_vals(16'h4321, 4'h0, 4'b0100, 4'h0);
    tick(16);

    load_vals(16'h89CD, 4'b0001, 4'h0, 4'h0);
    tick(16);
    load_vals(16'h89CD, 4'b0001, 4'b0001, 4'h0);
    tick(16);

    // Load landing exactly on a scan-advance edge.
    for (int g = 0; g < 8 && (c_edges % 4) != 3; g++) tick(1);
    load_vals(16'h3456, 4'b1010, 4'h0, 4'h0);
    tick(8);

    // Load held high with a changing value.
    bus.load = 1'b1;
    for (int v = 0; v < 6; v++) begin
      bus.value_in = 16'hE000 + 16'(v * 16'h0111);
      tick(1);
    end
    bus.load = 1'b0;
    tick(8);

    bus.value_in = 16'hFFFF;
    tick(16);

    // Reset while digit 2 is on the pins.
    for (int g = 0; g < 20 && !(c_edges >= 1 && ((c_edges - 1) / 4) % 4 == 2); g++) tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(12);

    tick(1);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish by %0t, want finish", $time);
    $fatal(1, "timeout");
  end
endmodule
